// File: rtl/data_mem_access_unit_pkg.sv
// Shared types and constants for the byte-serial data-memory port.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_LAST,
    WR,
    DONE,
    ERR
  } mem_state_t;

  localparam logic [1:0] MEM_CTRL_READ  = 2'b10;
  localparam logic [1:0] MEM_CTRL_WRITE = 2'b01;
  localparam logic [1:0] MEM_CTRL_IDLE  = 2'b00;

  localparam int BEATS_PER_WORD = 4;

  // Word access touches address..address+3; computed in 33 bits so it never wraps.
  function automatic logic word_out_of_range(input logic [31:0] addr, input int unsigned mem_size);
    logic [32:0] w_last;
    w_last = {1'b0, addr} + 33'd3;
    return w_last >= 33'(mem_size);
  endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Bundles the pipeline-side request/response signals and the byte-wide SRAM port.
interface data_mem_access_unit_if #(
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_ctrl_input;
  logic [31:0]       address;
  logic [31:0]       w_data;
  logic [31:0]       read_data;
  logic              mem_busy;
  logic              mem_done;
  logic              mem_err;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_re;
  logic              sram_we;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata;

  // The access unit itself.
  modport slave (
    input  mem_ctrl_input, address, w_data, sram_rdata,
    output read_data, mem_busy, mem_done, mem_err,
           sram_addr, sram_re, sram_we, sram_wdata
  );

  // The pipeline plus SRAM surrounding the unit.
  modport master (
    output mem_ctrl_input, address, w_data, sram_rdata,
    input  read_data, mem_busy, mem_done, mem_err,
           sram_addr, sram_re, sram_we, sram_wdata
  );
endinterface

// File: rtl/data_mem_access_unit_beat.sv
// Beat counter for one word access: holds the base byte address and produces base+beat.
module mem_beat_gen
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_base,
  output logic [1:0]        o_beat,
  output logic              o_last,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_beat <= '0;
    end else if (i_advance) begin
      r_beat <= r_beat + 2'd1;
    end
  end

  assign o_beat = r_beat;
  assign o_last = (r_beat == 2'(BEATS_PER_WORD - 1));
  assign o_addr = r_base + ADDR_W'(r_beat);

endmodule

// File: rtl/data_mem_access_unit.sv
// Serialises 32-bit loads/stores into four little-endian byte beats on a synchronous SRAM.
module data_mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int MEM_SIZE = 512,
  parameter int ADDR_W   = 9
) (
  input logic                   clk,
  input logic                   reset,
  data_mem_access_unit_if.slave bus
);

  mem_state_t        r_state;
  mem_state_t        w_state_next;
  logic [31:0]       r_wdata;
  logic [23:0]       r_shadow;
  logic [31:0]       r_read_data;

  logic [1:0]        w_req;
  logic              w_bad;
  logic              w_load;
  logic              w_advance;
  logic [1:0]        w_beat;
  logic              w_last;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [7:0]        w_wbyte [BEATS_PER_WORD];

  assign w_req  = bus.mem_ctrl_input;
  assign w_bad  = (w_req == 2'b11) || word_out_of_range(bus.address, MEM_SIZE);
  assign w_load = (r_state == IDLE) && ((w_state_next == RD) || (w_state_next == WR));

  genvar gi;
  generate
    for (gi = 0; gi < BEATS_PER_WORD; gi++) begin : g_wbyte
      assign w_wbyte[gi] = r_wdata[8*gi +: 8];
    end
  endgenerate

  mem_beat_gen #(
    .ADDR_W (ADDR_W)
  ) u_beat (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_base    (bus.address[ADDR_W-1:0]),
    .o_beat    (w_beat),
    .o_last    (w_last),
    .o_addr    (w_beat_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req != MEM_CTRL_IDLE) begin
          if (w_bad)                       w_state_next = ERR;
          else if (w_req == MEM_CTRL_READ) w_state_next = RD;
          else                             w_state_next = WR;
        end
      end
      RD: begin
        w_advance = 1'b1;
        if (w_last) w_state_next = RD_LAST;
      end
      RD_LAST: w_state_next = DONE;
      WR: begin
        w_advance = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // SRAM data lags the strobe by one cycle, so beat b delivers the byte requested in beat b-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdata     <= '0;
      r_shadow    <= '0;
      r_read_data <= '0;
    end else begin
      if (w_load) r_wdata <= bus.w_data;
      if (r_state == RD) begin
        for (int i = 0; i < BEATS_PER_WORD - 1; i++) begin
          if (w_beat == 2'(i + 1)) r_shadow[8*i +: 8] <= bus.sram_rdata;
        end
      end
      if (r_state == RD_LAST) r_read_data <= {bus.sram_rdata, r_shadow};
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.mem_busy   = (r_state == RD) || (r_state == RD_LAST) || (r_state == WR);
  assign bus.mem_done   = (r_state == DONE);
  assign bus.mem_err    = (r_state == ERR);
  assign bus.sram_re    = (r_state == RD);
  assign bus.sram_we    = (r_state == WR);
  assign bus.sram_addr  = ((r_state == RD) || (r_state == WR)) ? w_beat_addr : '0;
  assign bus.sram_wdata = (r_state == WR) ? w_wbyte[w_beat] : 8'h00;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench: byte-wide SRAM model around the unit, hand-computed expectations.
module tb_data_mem_access_unit;
  localparam int ADDR_W   = 9;
  localparam int MEM_SIZE = 512;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  logic [7:0]        sram [MEM_SIZE];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;

  int   done_cyc, done_n, err_cyc, err_n, re_n, we_n, both_n;

  data_mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_access_unit #(
    .MEM_SIZE (MEM_SIZE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write at the strobe edge, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (bus.sram_we) sram[bus.sram_addr] <= bus.sram_wdata;
    if (bus.sram_re) bus.sram_rdata <= sram[bus.sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and watch 10 cycles after the accept edge.
  task automatic run_access(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] wd);
    done_cyc = 0; done_n = 0; err_cyc = 0; err_n = 0; re_n = 0; we_n = 0; both_n = 0;
    @(negedge clk);
    bus.mem_ctrl_input = ctrl; bus.address = addr; bus.w_data = wd;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.sram_re) re_n++;
      if (bus.sram_we) we_n++;
      if (bus.sram_re && bus.sram_we) both_n++;
      if (bus.mem_done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = c;
        bus.mem_ctrl_input = 2'b00;
      end
      if (bus.mem_err) begin
        err_n++;
        if (err_cyc == 0) err_cyc = c;
        bus.mem_ctrl_input = 2'b00;
      end
    end
    $display("access ctrl=%b addr=0x%0h wdata=0x%0h: done@%0d err@%0d re=%0d we=%0d read_data=0x%0h",
             ctrl, addr, wd, done_cyc, err_cyc, re_n, we_n, bus.read_data);
  endtask

  initial begin
    checks = 0; fails = 0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.mem_ctrl_input = 2'b00; bus.address = '0; bus.w_data = '0; bus.sram_rdata = '0;
    reset = 1'b1;
    #1;
    check("reset_read_data", bus.read_data, 32'h0);
    check("reset_outputs", {28'h0, bus.mem_busy, bus.mem_done, bus.mem_err, bus.sram_re}, 32'h0);
    check("reset_sram_port", {22'h0, bus.sram_we, bus.sram_addr}, 32'h0);
    preload(9'h010, 8'h44); preload(9'h011, 8'h33);
    preload(9'h012, 8'h22); preload(9'h013, 8'h11);
    preload(9'h1FC, 8'h01); preload(9'h1FD, 8'h02);
    preload(9'h1FE, 8'h03); preload(9'h1FF, 8'h04);
    preload(9'h032, 8'h5A); preload(9'h033, 8'h6B);
    @(negedge clk);
    reset = 1'b0;

    // 1: aligned read
    run_access(2'b10, 32'h10, 32'h0);
    check("rd10_data", bus.read_data, 32'h11223344);
    check("rd10_done_cycle", done_cyc, 6);
    check("rd10_done_pulses", done_n, 1);
    check("rd10_re_cycles", re_n, 4);
    check("rd10_we_cycles", we_n, 0);

    // 2: aligned write and read-back
    run_access(2'b01, 32'h20, 32'hDEADBEEF);
    check("wr20_done_cycle", done_cyc, 5);
    check("wr20_we_cycles", we_n, 4);
    check("wr20_re_cycles", re_n, 0);
    check("wr20_sram", {sram[9'h023], sram[9'h022], sram[9'h021], sram[9'h020]}, 32'hDEADBEEF);
    check("wr20_byte0", {24'h0, sram[9'h020]}, 32'hEF);
    run_access(2'b10, 32'h20, 32'h0);
    check("rd20_data", bus.read_data, 32'hDEADBEEF);
    check("rd20_done_cycle", done_cyc, 6);

    // 3: both request bits set
    run_access(2'b11, 32'h40, 32'h12345678);
    check("ctrl11_err_cycle", err_cyc, 1);
    check("ctrl11_err_pulses", err_n, 1);
    check("ctrl11_no_done", done_n, 0);
    check("ctrl11_no_strobe", re_n + we_n, 0);
    check("ctrl11_read_data", bus.read_data, 32'hDEADBEEF);

    // 4: top-of-memory bounds
    run_access(2'b10, 32'h1FE, 32'h0);
    check("rd1fe_err_pulses", err_n, 1);
    check("rd1fe_no_strobe", re_n + we_n, 0);
    check("rd1fe_read_data", bus.read_data, 32'hDEADBEEF);
    run_access(2'b01, 32'h1FD, 32'hFFFFFFFF);
    check("wr1fd_err_pulses", err_n, 1);
    check("wr1fd_no_strobe", re_n + we_n, 0);
    check("wr1fd_sram_intact", {24'h0, sram[9'h1FF]}, 32'h04);
    run_access(2'b10, 32'h1FC, 32'h0);
    check("rd1fc_err", err_n, 0);
    check("rd1fc_data", bus.read_data, 32'h04030201);
    check("rd1fc_done_cycle", done_cyc, 6);

    // 5: misaligned write
    run_access(2'b01, 32'h05, 32'h01020304);
    check("wr05_sram", {sram[9'h008], sram[9'h007], sram[9'h006], sram[9'h005]}, 32'h01020304);
    check("wr05_byte0", {24'h0, sram[9'h005]}, 32'h04);
    check("wr05_done_cycle", done_cyc, 5);
    run_access(2'b10, 32'h05, 32'h0);
    check("rd05_data", bus.read_data, 32'h01020304);
    check("strobe_overlap", both_n, 0);

    // 6: reset during beat 2 of a write
    @(negedge clk);
    bus.mem_ctrl_input = 2'b01; bus.address = 32'h30; bus.w_data = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #1;
    check("wr30_beat2_we", {31'h0, bus.sram_we}, 32'h1);
    check("wr30_beat2_addr", {23'h0, bus.sram_addr}, 32'h032);
    reset = 1'b1;
    #1;
    check("rst_async_read_data", bus.read_data, 32'h0);
    check("rst_async_flags", {28'h0, bus.mem_busy, bus.mem_done, bus.mem_err, bus.sram_re}, 32'h0);
    check("rst_async_sram_port", {14'h0, bus.sram_we, bus.sram_wdata, bus.sram_addr}, 32'h0);
    bus.mem_ctrl_input = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_partial_sram",
          {sram[9'h033], sram[9'h032], sram[9'h031], sram[9'h030]}, 32'h6B5ACCDD);
    run_access(2'b10, 32'h30, 32'h0);
    check("rd30_after_rst", bus.read_data, 32'h6B5ACCDD);
    check("rd30_done_cycle", done_cyc, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
